// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch / next-PC controller.
// Boot-loads the PC, issues one instruction fetch at a time, hands the returned
// word to the core, then steers the PC register to the trap vector, a branch
// target or PC+1 when the core reports completion.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_value,
  output logic        pc_load,
  output logic        pc_inclement,
  output logic [31:0] pc_input,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  input  logic        halt,
  output logic        busy,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   trap_pend;
  logic   take_trap;  // exec_done cycle that redirects to TRAP_VECTOR
  logic   retire;     // exec_done cycle: instruction leaves the core
  logic   capture;    // instruction word arrives while waiting for it

  // Next-state and all PC / fetch controls; everything is forced low while
  // reset is asserted so the PC register and memory see no stray commands.
  always_comb begin
    state_nxt    = state;
    pc_load      = 1'b0;
    pc_inclement = 1'b0;
    pc_input     = 32'h0;
    imem_req     = 1'b0;
    imem_addr    = 32'h0;
    take_trap    = 1'b0;
    retire       = 1'b0;
    capture      = 1'b0;
    if (!reset) begin
      case (state)
        S_BOOT: begin
          pc_load   = 1'b1;
          pc_input  = RESET_VECTOR;
          state_nxt = S_REQ;
        end
        S_REQ: begin
          // halt wins over a new fetch: no request is presented at all
          if (halt) begin
            state_nxt = S_HALT;
          end else begin
            imem_req  = 1'b1;
            imem_addr = pc_value;
            if (imem_ready) state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            capture   = 1'b1;
            state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            retire    = 1'b1;
            state_nxt = S_REQ;
            if (trap_req || trap_pend) begin
              take_trap = 1'b1;
              pc_load   = 1'b1;
              pc_input  = TRAP_VECTOR;
            end else if (branch_taken) begin
              pc_load   = 1'b1;
              pc_input  = branch_target;
            end else begin
              pc_inclement = 1'b1;
            end
          end
        end
        S_HALT: begin
          if (!halt) state_nxt = S_REQ;
        end
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  assign busy = !reset && (state != S_HALT);

  // State register; reset abandons any fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= S_BOOT;
    else       state <= state_nxt;
  end

  // Trap latch: requests merge until the next retirement consumes them.
  always_ff @(posedge clk) begin
    if (reset)          trap_pend <= 1'b0;
    else if (take_trap) trap_pend <= 1'b0;
    else if (trap_req)  trap_pend <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset)       instret <= 32'h0;
    else if (retire) instret <= instret + 32'h1;
  end

  // Instruction register plus its one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_out   <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= capture;
      if (capture) instr_out <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h55;
  logic        pc_load, pc_inclement;
  logic [31:0] pc_input;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        exec_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        trap_req = 1'b0;
  logic        halt = 1'b0;
  logic        busy;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_instret = 32'h0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_value(pc),
    .pc_load(pc_load), .pc_inclement(pc_inclement), .pc_input(pc_input),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out),
    .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target), .trap_req(trap_req), .halt(halt),
    .busy(busy), .instret(instret)
  );

  always #5 clk = ~clk;

  // PC register driven by the sequencer's controls
  always @(posedge clk) begin
    if (pc_load)           pc <= pc_input;
    else if (pc_inclement) pc <= pc + 32'h1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // One instruction starting in S_REQ: fetch, respond, retire, one idle REQ cycle.
  task automatic run_instr(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] data, input logic br,
                           input logic [31:0] tgt, input logic trap_w,
                           input logic exp_load, input logic exp_inc,
                           input logic [31:0] exp_input, input logic [31:0] exp_pc);
    imem_ready = 1'b1;
    settle();
    chk({tag, ".req"}, {31'h0, imem_req}, 32'h1);
    chk({tag, ".addr"}, imem_addr, exp_addr);
    chk({tag, ".noload"}, {30'h0, pc_load, pc_inclement}, 32'h0);
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = data; trap_req = trap_w;
    settle();
    chk({tag, ".wait_noreq"}, {31'h0, imem_req}, 32'h0);
    step();
    imem_rvalid = 1'b0; trap_req = 1'b0;
    exec_done = 1'b1; branch_taken = br; branch_target = tgt;
    settle();
    chk({tag, ".ivalid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, ".iout"}, instr_out, data);
    chk({tag, ".load"}, {31'h0, pc_load}, {31'h0, exp_load});
    chk({tag, ".inc"}, {31'h0, pc_inclement}, {31'h0, exp_inc});
    chk({tag, ".pcin"}, pc_input, exp_input);
    step();
    exec_done = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    exp_instret = exp_instret + 32'h1;
    settle();
    chk({tag, ".instret"}, instret, exp_instret);
    chk({tag, ".pc"}, pc, exp_pc);
    chk({tag, ".ivalid_off"}, {31'h0, instr_valid}, 32'h0);
    step();
  endtask

  initial begin
    // T1: reset, boot, first instruction
    step();
    settle();
    chk("rst.load", {31'h0, pc_load}, 32'h0);
    chk("rst.req", {31'h0, imem_req}, 32'h0);
    chk("rst.ivalid", {31'h0, instr_valid}, 32'h0);
    chk("rst.instret", instret, 32'h0);
    step();
    reset = 1'b0;
    settle();
    chk("boot.load", {31'h0, pc_load}, 32'h1);
    chk("boot.pcin", pc_input, 32'h0);
    chk("boot.inc", {31'h0, pc_inclement}, 32'h0);
    chk("boot.busy", {31'h0, busy}, 32'h1);
    step();
    run_instr("t1", 32'h0, 32'hA000_0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1);

    // T2: memory stalls three cycles
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2.req", {31'h0, imem_req}, 32'h1);
      chk("t2.addr", imem_addr, 32'h1);
      chk("t2.ctl", {30'h0, pc_load, pc_inclement}, 32'h0);
      step();
    end
    run_instr("t2", 32'h1, 32'hB000_0002, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h2);
    run_instr("seq2", 32'h2, 32'h2222_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h3);
    run_instr("seq3", 32'h3, 32'h3333_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4);
    run_instr("seq4", 32'h4, 32'h4444_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h5);

    // T3: branch at PC=5 to 47
    run_instr("t3", 32'h5, 32'hC000_0003, 1'b1, 32'd47, 1'b0, 1'b1, 1'b0, 32'd47, 32'd47);
    // T4: trap pulse in S_WAIT beats a taken branch
    run_instr("t4", 32'd47, 32'hD000_0004, 1'b1, 32'd47, 1'b1, 1'b1, 1'b0, 32'h10, 32'h10);
    // trap consumed: next retire is a plain increment
    run_instr("t4b", 32'h10, 32'hD000_0005, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h11);

    // T6: reset while waiting, rvalid during and after reset
    imem_ready = 1'b1;
    settle();
    step();
    imem_ready = 1'b0; reset = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t6.rst_load", {31'h0, pc_load}, 32'h0);
    chk("t6.rst_req", {31'h0, imem_req}, 32'h0);
    step();
    reset = 1'b0;
    exp_instret = 32'h0;
    settle();
    chk("t6.ivalid", {31'h0, instr_valid}, 32'h0);
    chk("t6.instret", instret, 32'h0);
    chk("t6.boot_load", {31'h0, pc_load}, 32'h1);
    chk("t6.boot_pcin", pc_input, 32'h0);
    step();
    settle();
    chk("t6.late_ivalid", {31'h0, instr_valid}, 32'h0);
    chk("t6.req", {31'h0, imem_req}, 32'h1);
    chk("t6.addr", imem_addr, 32'h0);
    step();
    imem_rvalid = 1'b0;
    settle();
    chk("t6.late_ivalid2", {31'h0, instr_valid}, 32'h0);
    step();
    run_instr("t6a", 32'h0, 32'h6000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1);
    run_instr("t6b", 32'h1, 32'h6000_0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h2);

    // T5: halt raised in S_EXEC, exec_done at PC=2
    imem_ready = 1'b1;
    settle();
    step();
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5000_0002;
    settle();
    step();
    imem_rvalid = 1'b0; exec_done = 1'b1; halt = 1'b1;
    settle();
    chk("t5.inc", {31'h0, pc_inclement}, 32'h1);
    chk("t5.load", {31'h0, pc_load}, 32'h0);
    step();
    exec_done = 1'b0;
    exp_instret = exp_instret + 32'h1;
    settle();
    chk("t5.noreq", {31'h0, imem_req}, 32'h0);
    chk("t5.pc", pc, 32'h3);
    chk("t5.instret", instret, exp_instret);
    step();
    trap_req = 1'b1;
    settle();
    chk("t5.busy", {31'h0, busy}, 32'h0);
    chk("t5.halt_noreq", {31'h0, imem_req}, 32'h0);
    step();
    trap_req = 1'b0;
    settle();
    chk("t5.busy2", {31'h0, busy}, 32'h0);
    chk("t5.halt_ctl", {30'h0, pc_load, pc_inclement}, 32'h0);
    chk("t5.halt_pc", pc, 32'h3);
    step();
    halt = 1'b0;
    settle();
    chk("t5.busy3", {31'h0, busy}, 32'h0);
    step();
    // pending trap survives the halt and beats the branch
    run_instr("t5r", 32'h3, 32'h5000_0003, 1'b1, 32'd47, 1'b0, 1'b1, 1'b0, 32'h10, 32'h10);
    run_instr("t5c", 32'h10, 32'h5000_0004, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
